matrix_addsub_stream: RTL



---
 rtl/matrix_addsub_stream_pkg.sv | 27 ++
 rtl/matrix_addsub_stream_elem.sv | 20 ++
 rtl/matrix_addsub_stream.sv | 134 +++++++++++++
 3 files changed

// File: rtl/matrix_addsub_stream_pkg.sv
// Shared types and element arithmetic for the matrix add/subtract stream engine.
package matrix_ops_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

    // Widest element the helper handles; callers truncate to W+1 bits.
    localparam int unsigned MAX_W = 32;

    // Zero-extended add or subtract; the low W+1 bits of the result are exact
    // for any W-bit unsigned operands (two's complement when subtracting).
    function automatic logic [MAX_W:0] addsub_elem(input logic [MAX_W-1:0] a,
                                                   input logic [MAX_W-1:0] b,
                                                   input logic             mode);
        if (mode == MODE_ADD)
            return {1'b0, a} + {1'b0, b};
        else
            return {1'b0, a} - {1'b0, b};
    endfunction

endpackage

// File: rtl/matrix_addsub_stream_elem.sv
// Combinational W-bit element add/subtract producing {data, neg}.
module matrix_elem_addsub
    import matrix_ops_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mode,
    output logic [W:0]   data,
    output logic         neg
);

    // Element result; the sign bit only means "negative" in subtract mode.
    always_comb begin
        data = (W+1)'(addsub_elem(MAX_W'(a), MAX_W'(b), mode));
        neg  = (mode == MODE_SUB) && data[W];
    end

endmodule

// File: rtl/matrix_addsub_stream.sv
// NxN element-wise add/subtract engine: loads a full matrix of operand pairs
// over a valid/ready stream, then drains the results row-major with a last marker.
module matrix_addsub_stream
    import matrix_ops_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_data,
    output logic         out_neg,
    output logic         out_last,
    output logic         out_mode,
    output logic         busy
);

    localparam int unsigned ELEMS = N * N;
    localparam int unsigned CW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(ELEMS - 1);

    state_t        state;
    logic [CW-1:0] idx;
    logic [CW-1:0] nxt_idx;
    logic          mode_q;
    logic          cur_mode;
    logic          in_fire;
    logic          out_fire;
    logic [W:0]    res_data;
    logic          res_neg;
    logic [W+1:0]  buffer [ELEMS];

    // Mode is taken live on element 0 and from the latch for the rest of the matrix.
    always_comb begin
        cur_mode = (state == IDLE) ? mode : mode_q;
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        nxt_idx  = (idx == LAST_IDX) ? '0 : idx + CW'(1);
    end

    matrix_elem_addsub #(
        .W(W)
    ) u_elem (
        .a    (in_a),
        .b    (in_b),
        .mode (cur_mode),
        .data (res_data),
        .neg  (res_neg)
    );

    // Result buffer write port: one element per accepted operand pair.
    always_ff @(posedge clk) begin
        if (in_fire && !clear)
            buffer[idx] <= {res_neg, res_data};
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            mode_q    <= MODE_SUB;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_neg   <= 1'b0;
            out_last  <= 1'b0;
            out_mode  <= 1'b0;
            busy      <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (in_fire) begin
                        if (state == IDLE)
                            mode_q <= mode;
                        busy <= 1'b1;
                        idx  <= nxt_idx;
                        if (idx == LAST_IDX) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_mode  <= cur_mode;
                            out_last  <= (LAST_IDX == '0);
                            // Single-element matrix: the buffer write is still in flight,
                            // so present the freshly computed result directly.
                            if (ELEMS == 1) begin
                                out_data <= res_data;
                                out_neg  <= res_neg;
                            end else begin
                                out_data <= buffer[0][W:0];
                                out_neg  <= buffer[0][W+1];
                            end
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        idx <= nxt_idx;
                        if (idx == LAST_IDX) begin
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            out_data <= buffer[nxt_idx][W:0];
                            out_neg  <= buffer[nxt_idx][W+1];
                            out_last <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
